// File: rtl/iso_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iso_phy_pkg
// Description : Shared constants and the 8-step DisplayPort scrambler LFSR
//               helper used by the isochronous scrambler.
// Revision    : 1.0 - initial release
// ============================================================================
package iso_phy_pkg;

  localparam logic [7:0]  K_BS     = 8'hBC;    // K28.5 blanking start
  localparam logic [7:0]  K_SR     = 8'h1C;    // K28.0 scrambler reset
  localparam logic [15:0] SCR_POLY = 16'h0039; // X16+X5+X4+X3+1, Galois taps
  localparam logic [15:0] SCR_SEED = 16'hFFFF;

  // Eight unrolled Galois steps; returns {next_lfsr, s[7:0]} with s[i] from step i.
  function automatic logic [23:0] scr_lfsr_step8(input logic [15:0] lfsr_in);
    logic [15:0] l;
    logic [7:0]  s;
    l = lfsr_in;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? SCR_POLY : 16'h0000);
    end
    return {l, s};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iso_scrambler_lane.sv
`default_nettype none
// ============================================================================
// Module      : iso_scrambler_lane
// Description : One lane of the isochronous scrambler: per-lane LFSR, SR
//               substitution, data XOR and the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module iso_scrambler_lane
  import iso_phy_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = SCR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lane_active,
  input  logic       sr_event,
  input  logic       scr_dis,
  input  logic [7:0] sym_in,
  input  logic       flag_in,
  output logic [7:0] sym_out,
  output logic       flag_out
);

  logic [15:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [7:0]  scr_byte;
  logic [7:0]  sym_q, sym_d;
  logic        flag_q, flag_d;
  logic        is_bs;

  // Next LFSR state and output symbol for this cycle's input.
  always_comb begin
    {lfsr_nxt, scr_byte} = scr_lfsr_step8(lfsr_q);
    is_bs  = flag_in && (sym_in == K_BS);
    lfsr_d = lfsr_nxt;
    sym_d  = '0;
    flag_d = 1'b0;
    if (!enable) begin
      lfsr_d = LFSR_SEED;
    end else begin
      // The LFSR keeps running on inactive lanes so a later lane-count
      // change lines them up with lane0 immediately.
      if (sr_event) begin
        lfsr_d = LFSR_SEED;
      end
      if (lane_active) begin
        if (sr_event && is_bs) begin
          sym_d  = K_SR;
          flag_d = 1'b1;
        end else if (sr_event || flag_in) begin
          sym_d  = sym_in;
          flag_d = flag_in;
        end else begin
          sym_d  = scr_dis ? sym_in : (sym_in ^ scr_byte);
          flag_d = 1'b0;
        end
      end
    end
  end

  // Lane state and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      sym_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      sym_q  <= sym_d;
      flag_q <= flag_d;
    end
  end

  assign sym_out  = sym_q;
  assign flag_out = flag_q;

endmodule
`default_nettype wire

// File: rtl/iso_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : iso_scrambler
// Description : Four-lane DisplayPort isochronous scrambler with periodic
//               BS->SR substitution; one registered stage, 1 clk latency.
// Revision    : 1.0 - initial release
// ============================================================================
module iso_scrambler
  import iso_phy_pkg::*;
#(
  parameter int          NUM_LANES   = 4,
  parameter int          SR_INTERVAL = 512,
  parameter logic [15:0] LFSR_SEED   = SCR_SEED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_LANES*8-1:0] iso_symbols,
  input  logic [NUM_LANES-1:0]   iso_control_sym_flag,
  input  logic                   spm_iso_start,
  input  logic [2:0]             spm_lane_count,
  input  logic                   spm_scrambler_dis,
  output logic [NUM_LANES*8-1:0] scr_symbols,
  output logic [NUM_LANES-1:0]   scr_control_sym_flag,
  output logic                   scr_sr_event
);

  localparam int CNT_W = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;

  logic [CNT_W-1:0]     bs_cnt_q, bs_cnt_d;
  logic                 sr_event_q, sr_event_d;
  logic                 bs_det;
  logic [NUM_LANES-1:0] lane_active;
  int                   n_active;

  // BS detection on lane0, SR decision, BS counter and lane-count decode.
  always_comb begin
    bs_det     = iso_control_sym_flag[0] && (iso_symbols[7:0] == K_BS);
    sr_event_d = spm_iso_start && bs_det && (bs_cnt_q == '0);
    bs_cnt_d   = bs_cnt_q;
    if (!spm_iso_start) begin
      bs_cnt_d = '0;
    end else if (bs_det) begin
      // SR_INTERVAL is a power of two, so natural wrap gives the modulus.
      bs_cnt_d = bs_cnt_q + 1'b1;
    end
    case (spm_lane_count)
      3'd2:    n_active = 2;
      3'd4:    n_active = 4;
      default: n_active = 1;
    endcase
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_active[k] = (k < n_active);
    end
  end

  // BS counter and SR event pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs_cnt_q   <= '0;
      sr_event_q <= 1'b0;
    end else begin
      bs_cnt_q   <= bs_cnt_d;
      sr_event_q <= sr_event_d;
    end
  end

  assign scr_sr_event = sr_event_q;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    iso_scrambler_lane #(
      .LFSR_SEED (LFSR_SEED)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (spm_iso_start),
      .lane_active (lane_active[k]),
      .sr_event    (sr_event_d),
      .scr_dis     (spm_scrambler_dis),
      .sym_in      (iso_symbols[8*k +: 8]),
      .flag_in     (iso_control_sym_flag[k]),
      .sym_out     (scr_symbols[8*k +: 8]),
      .flag_out    (scr_control_sym_flag[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_iso_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : tb_iso_scrambler
// Description : Self-checking bench for iso_scrambler with a reference
//               scrambler model feeding an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iso_scrambler;

  logic        clk;
  logic        rst_n;
  logic [31:0] iso_symbols;
  logic [3:0]  iso_control_sym_flag;
  logic        spm_iso_start;
  logic [2:0]  spm_lane_count;
  logic        spm_scrambler_dis;
  logic [31:0] scr_symbols;
  logic [3:0]  scr_control_sym_flag;
  logic        scr_sr_event;

  iso_scrambler #(
    .NUM_LANES   (4),
    .SR_INTERVAL (512),
    .LFSR_SEED   (16'hFFFF)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .iso_symbols          (iso_symbols),
    .iso_control_sym_flag (iso_control_sym_flag),
    .spm_iso_start        (spm_iso_start),
    .spm_lane_count       (spm_lane_count),
    .spm_scrambler_dis    (spm_scrambler_dis),
    .scr_symbols          (scr_symbols),
    .scr_control_sym_flag (scr_control_sym_flag),
    .scr_sr_event         (scr_sr_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sym;
    logic [3:0]  flg;
    logic        sr;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lfsr = 16'hFFFF;
  int          m_cnt  = 0;
  logic [31:0] last_sym;
  logic [3:0]  last_flg;
  logic        last_sr;

  function automatic logic [31:0] rep4(input logic [7:0] b);
    return {4{b}};
  endfunction

  // Drive one input cycle, predict its output, and compare one clock later.
  task automatic drive(input logic [31:0] sym, input logic [3:0] flg);
    exp_t        e;
    logic [15:0] l;
    logic [7:0]  s;
    logic [7:0]  b;
    logic        bs, sr;
    int          nact;
    iso_symbols          = sym;
    iso_control_sym_flag = flg;
    e.sym = '0;
    e.flg = '0;
    e.sr  = 1'b0;
    if (!spm_iso_start) begin
      m_lfsr = 16'hFFFF;
      m_cnt  = 0;
    end else begin
      bs = flg[0] && (sym[7:0] == 8'hBC);
      sr = bs && (m_cnt == 0);
      if (bs) m_cnt = (m_cnt + 1) % 512;
      nact = (spm_lane_count == 3'd2) ? 2 : (spm_lane_count == 3'd4) ? 4 : 1;
      l = m_lfsr;
      s = '0;
      for (int i = 0; i < 8; i++) begin
        s[i] = l[15];
        l = l[15] ? ({l[14:0], 1'b0} ^ 16'h0039) : {l[14:0], 1'b0};
      end
      for (int k = 0; k < nact; k++) begin
        b = sym[k*8 +: 8];
        if (sr && flg[k] && b == 8'hBC) begin
          e.sym[k*8 +: 8] = 8'h1C;
          e.flg[k]        = 1'b1;
        end else if (sr || flg[k]) begin
          e.sym[k*8 +: 8] = b;
          e.flg[k]        = flg[k];
        end else begin
          e.sym[k*8 +: 8] = spm_scrambler_dis ? b : (b ^ s);
          e.flg[k]        = 1'b0;
        end
      end
      e.sr   = sr;
      m_lfsr = sr ? 16'hFFFF : l;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (scr_symbols !== e.sym) begin
      errors++;
      $display("FAIL sb_symbols t=%0t got=%h exp=%h", $time, scr_symbols, e.sym);
    end
    checks++;
    if (scr_control_sym_flag !== e.flg) begin
      errors++;
      $display("FAIL sb_flags t=%0t got=%b exp=%b", $time, scr_control_sym_flag, e.flg);
    end
    checks++;
    if (scr_sr_event !== e.sr) begin
      errors++;
      $display("FAIL sb_sr_event t=%0t got=%b exp=%b", $time, scr_sr_event, e.sr);
    end
    last_sym = scr_symbols;
    last_flg = scr_control_sym_flag;
    last_sr  = scr_sr_event;
  endtask

  // One disabled cycle restarts the LFSR and BS counter.
  task automatic restart();
    spm_iso_start = 1'b0;
    drive(32'h0, 4'h0);
    spm_iso_start = 1'b1;
  endtask

  task automatic test_reset();
    rst_n                = 1'b0;
    spm_iso_start        = 1'b0;
    spm_lane_count       = 3'd4;
    spm_scrambler_dis    = 1'b0;
    iso_symbols          = 32'hDEADBEEF;
    iso_control_sym_flag = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (scr_symbols !== 32'h0 || scr_control_sym_flag !== 4'h0 || scr_sr_event !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%h/%b/%b exp=0/0/0", scr_symbols, scr_control_sym_flag, scr_sr_event);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_sr();
    spm_iso_start = 1'b1;
    drive(rep4(8'hBC), 4'hF);
    checks++;
    if (last_sym !== rep4(8'h1C) || last_flg !== 4'hF || last_sr !== 1'b1) begin
      errors++;
      $display("FAIL first_sr got=%h/%b/%b exp=1c1c1c1c/1111/1", last_sym, last_flg, last_sr);
    end
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'hFF)) begin
      errors++;
      $display("FAIL seed_byte0 got=%h exp=ffffffff", last_sym);
    end
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'h17)) begin
      errors++;
      $display("FAIL seed_byte1 got=%h exp=17171717", last_sym);
    end
  endtask

  task automatic test_sr_interval();
    int          sr_idx[$];
    logic [31:0] d;
    restart();
    for (int n = 0; n < 600; n++) begin
      drive(rep4(8'hBC), 4'hF);
      if (last_sr) sr_idx.push_back(n);
      for (int j = 0; j < 3; j++) begin
        d = $urandom;
        drive(d, 4'h0);
        if (n == 512 && j == 0) begin
          checks++;
          if (last_sym !== (d ^ rep4(8'hFF))) begin
            errors++;
            $display("FAIL sr513_restart got=%h exp=%h", last_sym, d ^ rep4(8'hFF));
          end
        end
      end
    end
    checks++;
    if (sr_idx.size() != 2 || sr_idx[0] != 0 || sr_idx[1] != 512) begin
      errors++;
      $display("FAIL sr_positions got_count=%0d exp_count=2 (BS #1 and #513)", sr_idx.size());
    end
  endtask

  task automatic test_control();
    restart();
    drive(rep4(8'hBC), 4'hF);
    drive(rep4(8'hFB), 4'hF);
    checks++;
    if (last_sym !== rep4(8'hFB) || last_flg !== 4'hF) begin
      errors++;
      $display("FAIL ctrl_pass got=%h/%b exp=fbfbfbfb/1111", last_sym, last_flg);
    end
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'h17)) begin
      errors++;
      $display("FAIL ctrl_lfsr_adv got=%h exp=17171717", last_sym);
    end
  endtask

  task automatic test_lane_count();
    restart();
    spm_lane_count = 3'd2;
    drive(rep4(8'hBC), 4'hF);
    drive(32'h12345678, 4'h0);
    checks++;
    if (last_sym[31:16] !== 16'h0 || last_flg[3:2] !== 2'b00) begin
      errors++;
      $display("FAIL lanes23_idle got=%h/%b exp=0000/00", last_sym[31:16], last_flg[3:2]);
    end
    spm_lane_count = 3'd4;
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'h17)) begin
      errors++;
      $display("FAIL lanes_switch got=%h exp=17171717", last_sym);
    end
    spm_lane_count = 3'd3;
    drive(32'hA1B2C3D4, 4'h0);
    checks++;
    if (last_sym[31:8] !== 24'h0) begin
      errors++;
      $display("FAIL lanecount3_as1 got=%h exp=000000", last_sym[31:8]);
    end
    spm_lane_count = 3'd4;
  endtask

  task automatic test_scr_dis();
    restart();
    drive(rep4(8'hBC), 4'hF);
    spm_scrambler_dis = 1'b1;
    drive(rep4(8'hA5), 4'h0);
    checks++;
    if (last_sym !== rep4(8'hA5)) begin
      errors++;
      $display("FAIL scr_dis got=%h exp=a5a5a5a5", last_sym);
    end
    spm_scrambler_dis = 1'b0;
    drive(rep4(8'hA5), 4'h0);
    checks++;
    if (last_sym !== rep4(8'hB2)) begin
      errors++;
      $display("FAIL scr_reenable got=%h exp=b2b2b2b2", last_sym);
    end
  endtask

  task automatic test_start_toggle();
    drive(rep4(8'h3C), 4'h0);
    spm_iso_start = 1'b0;
    drive(rep4(8'h55), 4'h0);
    checks++;
    if (last_sym !== 32'h0 || last_flg !== 4'h0) begin
      errors++;
      $display("FAIL start_off got=%h/%b exp=0/0", last_sym, last_flg);
    end
    spm_iso_start = 1'b1;
    drive(rep4(8'h11), 4'h0);
    checks++;
    if (last_sym !== rep4(8'hEE)) begin
      errors++;
      $display("FAIL start_seed got=%h exp=eeeeeeee", last_sym);
    end
    drive(rep4(8'hBC), 4'hF);
    checks++;
    if (last_sr !== 1'b1) begin
      errors++;
      $display("FAIL start_sr got=%b exp=1", last_sr);
    end
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'hFF)) begin
      errors++;
      $display("FAIL start_after_sr got=%h exp=ffffffff", last_sym);
    end
  endtask

  task automatic test_reset_mid();
    drive(rep4(8'hBC), 4'hF);
    drive(32'hCAFEF00D, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (scr_symbols !== 32'h0 || scr_control_sym_flag !== 4'h0 || scr_sr_event !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=%h/%b/%b exp=0/0/0", scr_symbols, scr_control_sym_flag, scr_sr_event);
    end
    m_lfsr = 16'hFFFF;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(rep4(8'hBC), 4'hF);
    checks++;
    if (last_sr !== 1'b1 || last_sym !== rep4(8'h1C)) begin
      errors++;
      $display("FAIL reset_sr got=%b/%h exp=1/1c1c1c1c", last_sr, last_sym);
    end
    drive(32'h0, 4'h0);
    checks++;
    if (last_sym !== rep4(8'hFF)) begin
      errors++;
      $display("FAIL reset_seed got=%h exp=ffffffff", last_sym);
    end
  endtask

  initial begin
    test_reset();
    test_first_sr();
    test_sr_interval();
    test_control();
    test_lane_count();
    test_scr_dis();
    test_start_toggle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iso_scrambler.md
Name: iso_scrambler

Overview:
- Downstream neighbour of the isochronous transport top, in the ls_clk domain.
- Takes the four per-lane symbol/control-flag streams and replaces every 512th BS with SR on all active lanes.
- Scrambles data symbols with the DisplayPort 16-bit LFSR; control symbols are never scrambled.
- Output is one registered stage, feeding the per-lane 8b/10b encoders.

Parameters:
- NUM_LANES, 4, number of lanes; packed ports are NUM_LANES*8 / NUM_LANES wide.
- SR_INTERVAL, 512, BS count period for SR substitution; must be a power of 2.
- LFSR_SEED, 16'hFFFF, LFSR value after reset and on SR.

Ports:
- clk  in  1  link symbol clock (ls_clk).
- rst_n  in  1  asynchronous active-low reset.
- iso_symbols  in  NUM_LANES*8  lane k symbol at [8k+7:8k].
- iso_control_sym_flag  in  NUM_LANES  bit k=1: lane k symbol is a K-code.
- spm_iso_start  in  1  block enable.
- spm_lane_count  in  3  active lanes: 1, 2 or 4.
- spm_scrambler_dis  in  1  1 = data passes unscrambled (training / debug).
- scr_symbols  out  NUM_LANES*8  registered output symbols.
- scr_control_sym_flag  out  NUM_LANES  registered K flags.
- scr_sr_event  out  1  one-cycle pulse aligned with an emitted SR.

Behaviour:
- Reset (rst_n=0, async): scr_symbols=0, scr_control_sym_flag=0, scr_sr_event=0, every lane LFSR=LFSR_SEED, bs_cnt=0.
- Latency: exactly 1 clk from input to output, every cycle. There is no valid handshake; the input stream is continuous.
- spm_iso_start=0 (synchronous): outputs driven 0, LFSRs loaded with LFSR_SEED, bs_cnt=0.
- Active lanes:
  - spm_lane_count=1: lane0 only. 2: lanes 0-1. 4: all lanes.
  - Any other value behaves as 1.
  - Inactive lanes output symbol 0 and flag 0; their LFSRs run identically to lane0's.
- BS detect: lane0 flag=1 and symbol=8'hBC (K28.5). Only lane0 is counted; BS on other lanes alone is ignored.
- SR event: a BS is detected and bs_cnt==0.
  - bs_cnt increments modulo SR_INTERVAL on every detected BS.
  - The first BS after enable or reset is therefore replaced by SR.
- On an SR event:
  - Each active lane whose input is BS (flag=1, 8'hBC) outputs 8'h1C (K28.0, SR) with flag=1.
  - Active lanes not carrying BS pass their symbol through unchanged.
  - All LFSRs load LFSR_SEED; the next symbol uses the seed.
  - scr_sr_event=1 with the output.
- Control symbol, non-SR: passed through unchanged, flag=1; LFSR advances 8 steps.
- Data symbol (flag=0): out[i] = in[i] XOR s[i], i=0..7; flag=0; LFSR advances 8 steps.
  - With spm_scrambler_dis=1, out=in, but the LFSR still advances and SR substitution still applies.
- LFSR step (Galois, G(X)=X16+X5+X4+X3+1):
  - s = lfsr[15]; fb = lfsr[15].
  - lfsr = {lfsr[14:0],1'b0} ^ (fb ? 16'h0039 : 16'h0000).
  - s[i] is the bit produced by step i of the 8 steps in a cycle.
  - Implemented as unrolled combinational 8-step logic per lane.
- Known sequence from the seed: scramble bytes 8'hFF, then 8'h17; LFSR after the first byte = 16'hE817.
- spm_lane_count change mid-stream: takes effect the next cycle. LFSRs and bs_cnt are not reset.
- rst_n asserted mid-frame: immediate return to reset values. The first BS after release is SR.

Decomposition:
- Shared package iso_phy_pkg:
  - constants K_BS=8'hBC, K_SR=8'h1C, SCR_POLY=16'h0039, SCR_SEED=16'hFFFF;
  - function scr_lfsr_step8 returning {next_lfsr, s[7:0]}.
- One sub-module, iso_scrambler_lane, instantiated NUM_LANES times. It contains the LFSR, the XOR logic and the output register.
- The top holds bs_cnt, BS detection, lane-count decode and scr_sr_event.

Test Plan:
- Reset, enable, 4 lanes; lane0 BS then data 8'h00,8'h00 on all lanes -> first output SR 8'h1C flag=1 with scr_sr_event=1, then 8'hFF, then 8'h17 on every lane.
- 600 consecutive BS-terminated lines (BS, 3 data) -> SR on BS #1 and BS #513 only; all other BS output 8'hBC; LFSR restarts (next data 8'h00 -> 8'hFF) after each SR.
- Control symbol 8'hFB (K27.7) between data -> output 8'hFB flag=1 unscrambled; next data byte uses the LFSR advanced by 8 steps (data 8'h00 after BS-SR,K,data -> 8'h17).
- spm_lane_count=2 -> lanes 2-3 output 0/flag 0; lanes 0-1 scrambled correctly. Switch to 4 mid-line -> lanes 2-3 emit the same scramble sequence as lane0 from the next cycle.
- spm_scrambler_dis=1 with data 8'hA5 -> output 8'hA5. Re-enable scrambling -> output equals 8'hA5 XOR the LFSR byte as if scrambling had never stopped.
- Assert rst_n mid-line and spm_iso_start=0 for one cycle (separately) -> outputs 0 immediately/next cycle; next BS becomes SR, and data after it scrambles with 8'hFF.
